uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_transmitter_if.sv | 19 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_transmitter.sv | 120 ++++++++++++
 tb/tb_uart_transmitter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit shifter states, default
// bit period (50 MHz / 9600 baud), ASCII codes used by the message FSMs.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic [7:0] QUOTE = 8'h22;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte load handshake between a message FSM (master) and the UART (slave).
// txdata/ldtxdata: byte and one-cycle strobe; txempty: holding reg free.
interface uart_transmitter_if;
  logic [7:0] txdata;
  logic       ldtxdata;
  logic       txempty;

  modport master (
    output txdata,
    output ldtxdata,
    input  txempty
  );

  modport slave (
    input  txdata,
    input  ldtxdata,
    output txempty
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Ports: clk, reset (sync, high), en, clr in;
// tick out, high for one cycle when the count reaches CLKS_PER_BIT-1.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || !en)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Double-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
// Ports: clk, reset, bus (txdata/ldtxdata/txempty), txidle, tx.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_transmitter_if.slave    bus,
  output logic                 txidle,
  output logic                 tx
);

  tx_state_e  state;
  logic [7:0] hold;
  logic       hold_full;
  logic [7:0] data;
  logic [2:0] idx;
  logic       tx_q;
  logic       tick;
  logic       clr;

  // Counter restarts whenever a byte moves from holding to shifter.
  assign clr = hold_full &&
               ((state == IDLE) ||
                ((state == STOP) && tick));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .en   (state != IDLE),
    .clr  (clr),
    .tick (tick)
  );

  assign bus.txempty = !hold_full;
  assign tx          = tx_q;
  assign txidle      = (state == IDLE) && !hold_full && tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      data      <= '0;
      idx       <= '0;
      tx_q      <= 1'b1;
    end else begin
      // Load and hand-off are exclusive: one needs
      // holding empty, the other holding full.
      if (bus.ldtxdata && !hold_full) begin
        hold      <= bus.txdata;
        hold_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (hold_full) begin
            data      <= hold;
            hold_full <= 1'b0;
            tx_q      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            idx   <= '0;
            tx_q  <= data[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= ^data;
              state <= PARITY;
`else
              tx_q  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              idx  <= idx + 3'd1;
              tx_q <= data[idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (hold_full) begin
              data      <= hold;
              hold_full <= 1'b0;
              tx_q      <= 1'b0;
              state     <= START;
            end else begin
              tx_q  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: CLKS_PER_BIT=4 (dut) and 2 (dut2).
// Both instances share stimulus; each test checks its own expectations.
module tb_uart_transmitter;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int C1 = 4;
  localparam int C2 = 2;
  localparam int F1 = NB * C1;
  localparam int F2 = NB * C2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txidle, tx, txidle2, tx2;

  uart_transmitter_if bus ();
  uart_transmitter_if bus2 ();

  assign bus2.txdata   = bus.txdata;
  assign bus2.ldtxdata = bus.ldtxdata;

  uart_transmitter #(.CLKS_PER_BIT(C1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .txidle(txidle),
    .tx    (tx)
  );

  uart_transmitter #(.CLKS_PER_BIT(C2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave),
    .txidle(txidle2),
    .tx    (tx2)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  logic rec_tx    [300];
  logic rec_empty [300];
  logic rec_idle  [300];
  logic rec_tx2   [300];
  logic rec_idle2 [300];

  logic [7:0] bq[$];
  int         lc[$];

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic int frame_err(input int start, input logic [7:0] d,
                                   input int cpb, input bit sel);
    int n = 0;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < cpb; c++) begin
        logic v;
        v = sel ? rec_tx2[start + b*cpb + c] : rec_tx[start + b*cpb + c];
        if (v !== exp_bit(d, b)) n++;
      end
    return n;
  endfunction

  function automatic int high_err(input int from, input int to, input bit sel);
    int n = 0;
    for (int k = from; k <= to; k++)
      if ((sel ? rec_tx2[k] : rec_tx[k]) !== 1'b1) n++;
    return n;
  endfunction

  // Records outputs at each negedge, then drives that cycle's load.
  task automatic run(input int n, input bit autold);
    int bi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rec_tx[k]    = tx;
      rec_empty[k] = bus.txempty;
      rec_idle[k]  = txidle;
      rec_tx2[k]   = tx2;
      rec_idle2[k] = txidle2;
      bus.ldtxdata = 1'b0;
      if (bi < bq.size()) begin
        if (autold ? (bus.txempty === 1'b1) : (lc[bi] == k)) begin
          bus.ldtxdata = 1'b1;
          bus.txdata   = bq[bi];
          bi++;
        end
      end
    end
    @(negedge clk);
    bus.ldtxdata = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.ldtxdata = 1'b1;
    bus.txdata = 8'hFF;
    @(negedge clk);
    total++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx);
    else pass_cnt++;
    total++;
    if (bus.txempty !== 1'b1) $display("FAIL reset_txempty got %b want 1", bus.txempty);
    else pass_cnt++;
    total++;
    if (txidle !== 1'b1) $display("FAIL reset_txidle got %b want 1", txidle);
    else pass_cnt++;
    reset = 1'b0;
    bus.ldtxdata = 1'b0;
    @(negedge clk);
    total++;
    if (bus.txempty !== 1'b1 || txidle !== 1'b1)
      $display("FAIL reset_ld_ignored got empty=%b idle=%b want 1/1",
               bus.txempty, txidle);
    else pass_cnt++;
    total++;
    if (tx2 !== 1'b1) $display("FAIL reset_tx2 got %b want 1", tx2);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int e;
    bq = {QUOTE}; lc = {0};
    run(60, 1'b0);
    total++;
    if (rec_empty[1] !== 1'b0 || rec_empty[2] !== 1'b1)
      $display("FAIL single_txempty got %b%b want 01", rec_empty[1], rec_empty[2]);
    else pass_cnt++;
    total++;
    if (rec_idle[1] !== 1'b0) $display("FAIL single_idle_drop got %b want 0", rec_idle[1]);
    else pass_cnt++;
    total++;
    if (rec_tx[1] !== 1'b1 || rec_tx[2] !== 1'b0)
      $display("FAIL single_latency got %b%b want 10", rec_tx[1], rec_tx[2]);
    else pass_cnt++;
    e = frame_err(2, QUOTE, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL single_frame got %0d bad cycles want 0", e);
    else pass_cnt++;
    total++;
    if (rec_idle[1+F1] !== 1'b0 || rec_idle[2+F1] !== 1'b1)
      $display("FAIL single_idle_return got %b%b want 01",
               rec_idle[1+F1], rec_idle[2+F1]);
    else pass_cnt++;
    e = high_err(2 + F1, 59, 1'b0);
    total++;
    if (e !== 0) $display("FAIL single_tail got %0d low cycles want 0", e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int e;
    bq = {QUOTE, CR, LF}; lc = {};
    run(150, 1'b1);
    total++;
    if (rec_tx[1] !== 1'b1 || rec_tx[2] !== 1'b0)
      $display("FAIL b2b_first_fall got %b%b want 10", rec_tx[1], rec_tx[2]);
    else pass_cnt++;
    e = frame_err(2, QUOTE, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL b2b_frame0 got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = frame_err(2 + F1, CR, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL b2b_frame1 got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = frame_err(2 + 2*F1, LF, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL b2b_frame2 got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = high_err(2 + 3*F1, 149, 1'b0);
    total++;
    if (e !== 0 || rec_idle[2+3*F1] !== 1'b1)
      $display("FAIL b2b_end got low=%0d idle=%b want 0/1", e, rec_idle[2+3*F1]);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int e;
    bq = {8'h55, 8'hC3, 8'hFF}; lc = {0, 2, 3};
    run(160, 1'b0);
    total++;
    if (rec_empty[2] !== 1'b1 || rec_empty[3] !== 1'b0)
      $display("FAIL ovr_txempty got %b%b want 10", rec_empty[2], rec_empty[3]);
    else pass_cnt++;
    e = frame_err(2, 8'h55, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL ovr_frame0 got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = frame_err(2 + F1, 8'hC3, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL ovr_frame1 got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = high_err(2 + 2*F1, 159, 1'b0);
    total++;
    if (e !== 0) $display("FAIL ovr_dropped got %0d low cycles want 0", e);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int e = 0;
    int emp = 0;
    @(negedge clk);
    bus.ldtxdata = 1'b1;
    bus.txdata = 8'hA5;
    @(negedge clk);
    bus.ldtxdata = 1'b0;
    repeat (14) @(negedge clk);
    total++;
    if (tx !== exp_bit(8'hA5, 3))
      $display("FAIL mid_tx got %b want %b", tx, exp_bit(8'hA5, 3));
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (tx !== 1'b1 || bus.txempty !== 1'b1 || txidle !== 1'b1)
      $display("FAIL mid_reset got tx=%b empty=%b idle=%b want 1/1/1",
               tx, bus.txempty, txidle);
    else pass_cnt++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx2 !== 1'b1) e++;
      if (bus.txempty !== 1'b1) emp++;
    end
    total++;
    if (e !== 0 || emp !== 0)
      $display("FAIL mid_quiet got low=%0d notempty=%0d want 0/0", e, emp);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    int e;
    bq = {8'hA5}; lc = {0};
    run(50, 1'b0);
    total++;
    if (rec_tx2[1] !== 1'b1 || rec_tx2[2] !== 1'b0)
      $display("FAIL c2_latency got %b%b want 10", rec_tx2[1], rec_tx2[2]);
    else pass_cnt++;
    e = frame_err(2, 8'hA5, C2, 1'b1);
    total++;
    if (e !== 0) $display("FAIL c2_frame got %0d bad cycles want 0", e);
    else pass_cnt++;
    e = high_err(2 + F2, 49, 1'b1);
    total++;
    if (e !== 0 || rec_idle2[1+F2] !== 1'b0 || rec_idle2[2+F2] !== 1'b1)
      $display("FAIL c2_end got low=%0d idle=%b%b want 0/01",
               e, rec_idle2[1+F2], rec_idle2[2+F2]);
    else pass_cnt++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int e;
    bq = {CR, LF}; lc = {0, 2};
    run(110, 1'b0);
    total++;
    if (rec_tx[2 + 9*C1] !== 1'b1)
      $display("FAIL par_cr got %b want 1", rec_tx[2 + 9*C1]);
    else pass_cnt++;
    total++;
    if (rec_tx[2 + F1 + 9*C1] !== 1'b0)
      $display("FAIL par_lf got %b want 0", rec_tx[2 + F1 + 9*C1]);
    else pass_cnt++;
    e = frame_err(2, CR, C1, 1'b0) + frame_err(2 + F1, LF, C1, 1'b0);
    total++;
    if (e !== 0) $display("FAIL par_frames got %0d bad cycles want 0", e);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ldtxdata = 1'b0;
    bus.txdata = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_boundary();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
